fdd_spin_gen: RTL and testbench

Parametrised multi-drive floppy rotation and head-position emulator for the UKNC FDD path. It generates the raw-track word address stream and a word strobe from a clock divider. It keeps an independent track register per drive, produces index and track0 status, and computes the image LBA of the current sector. That LBA goes to the SD-card fetch engine over a req/ack handshake. It replaces the fixed 4-drive, async-motor-reset rotation logic with a synchronous, geometry-parametrised block.

---
 rtl/fdd_pkg.sv | 40 ++++
 rtl/fdd_step_sync.sv | 23 ++
 rtl/fdd_spin_gen.sv | 168 ++++++++++++++++
 tb/tb_fdd_spin_gen.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdd_pkg.sv
// Shared geometry defaults and LBA helper
// for the UKNC floppy rotation emulator.
package fdd_pkg;

  localparam int FDD_SECTORS        = 10;
  localparam int FDD_SEC_WORDS      = 307;
  localparam int FDD_LAST_SEC_WORDS = 362;
  localparam int FDD_SIDES          = 2;
  localparam int FDD_TRACKS         = 80;
  localparam int FDD_IMG_SECTORS    = 1600;
  localparam int FDD_SEC_BASE       = 4;

  localparam int FDD_REV_WORDS =
    (FDD_SECTORS - 1) * FDD_SEC_WORDS +
    FDD_LAST_SEC_WORDS;

  // SD sector of a floppy sector; 0 when no disk
  function automatic logic [31:0] lba_calc(
    input logic [7:0] trk,
    input logic       hd,
    input logic [3:0] sec,
    input logic [6:0] img,
    input int         sides,
    input int         sectors,
    input int         base,
    input int         img_secs
  );
    logic [31:0] r;
    r = '0;
    if (img != 7'd0) begin
      r = (32'(trk) * 32'(sides) + 32'(hd))
          * 32'(sectors)
        + 32'(sec)
        + 32'(base)
        + (32'(img) - 32'd1) * 32'(img_secs);
    end
    return r;
  endfunction

endpackage

// File: rtl/fdd_step_sync.sv
// Three-flop synchroniser with edge pulse;
// ANY_EDGE=1 pulses on both edges.
module fdd_step_sync #(
  parameter bit ANY_EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic [2:0] s;

  // shift the async level through three flops
  always_ff @(posedge clk) begin
    if (rst) s <= '0;
    else     s <= {s[1:0], d};
  end

  assign pulse = ANY_EDGE ? (s[1] ^ s[2])
                          : (s[1] & ~s[2]);

endmodule

// File: rtl/fdd_spin_gen.sv
// Multi-drive floppy rotation, head position
// and SD LBA request generator.
module fdd_spin_gen
  import fdd_pkg::*;
#(
  parameter int NUM_DRIVES     = 4,
  parameter int CLK_DIV        = 1600,
  parameter int SECTORS        = FDD_SECTORS,
  parameter int SEC_WORDS      = FDD_SEC_WORDS,
  parameter int LAST_SEC_WORDS = FDD_LAST_SEC_WORDS,
  parameter int SIDES          = FDD_SIDES,
  parameter int TRACKS         = FDD_TRACKS,
  parameter int IMG_SECTORS    = FDD_IMG_SECTORS,
  parameter int SEC_BASE       = FDD_SEC_BASE,
  parameter int INDEX_WORDS    = 8,
  parameter int INIT_TRACK     = 0,
  localparam int SW =
    (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1
) (
  input  logic                    pin_25mhz_ck,
  input  logic                    ppu_vm_init_i,
  input  logic [SW-1:0]           drive_sel,
  input  logic                    motor,
  input  logic                    step,
  input  logic                    dir,
  input  logic                    head,
  input  logic [7*NUM_DRIVES-1:0] disk_img,
  output logic [8:0]              word_addr,
  output logic                    word_valid,
  output logic [3:0]              sec_no,
  output logic                    index,
  output logic                    track0,
  output logic [7:0]              track_no,
  output logic                    ready,
  output logic [31:0]             lba,
  output logic                    lba_req,
  input  logic                    lba_ack
);

  localparam int DW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic                         clk;
  logic                         rst;
  logic [DW-1:0]                div;
  logic [NUM_DRIVES-1:0][7:0]   trk;
  logic [SW-1:0]                sel_q;
  logic                         motor_q;
  logic                         evt_q;
  logic                         step_p;
  logic                         head_p;
  logic                         tick;
  logic                         pos_rst;
  logic                         sec_end;
  logic                         evt;
  logic [6:0]                   img;
  logic [7:0]                   trk_cur;

  assign clk = pin_25mhz_ck;
  assign rst = ppu_vm_init_i;

  fdd_step_sync #(.ANY_EDGE(1'b0)) u_step (
    .clk   (clk),
    .rst   (rst),
    .d     (step),
    .pulse (step_p)
  );

  fdd_step_sync #(.ANY_EDGE(1'b1)) u_head (
    .clk   (clk),
    .rst   (rst),
    .d     (head),
    .pulse (head_p)
  );

  assign img     = disk_img[int'(drive_sel)*7 +: 7];
  assign trk_cur = trk[drive_sel];

  assign tick    = motor &&
                   (div == DW'(CLK_DIV - 1));
  assign pos_rst = step_p | head_p |
                   (drive_sel != sel_q);
  assign sec_end =
    (sec_no == 4'(SECTORS - 1))
      ? (word_addr == 9'(LAST_SEC_WORDS - 1))
      : (word_addr == 9'(SEC_WORDS - 1));
  assign evt     = pos_rst |
                   (tick & sec_end) |
                   (motor & ~motor_q);

  assign index = motor_q && (sec_no == 4'd0) &&
                 (word_addr < 9'(INDEX_WORDS));

  // divider and rotational position
  always_ff @(posedge clk) begin
    if (rst || !motor || pos_rst) begin
      div       <= '0;
      word_addr <= '0;
      sec_no    <= '0;
    end else if (tick) begin
      div <= '0;
      if (sec_end) begin
        word_addr <= '0;
        sec_no <= (sec_no == 4'(SECTORS - 1))
                  ? 4'd0 : sec_no + 4'd1;
      end else begin
        word_addr <= word_addr + 9'd1;
      end
    end else begin
      div <= div + DW'(1);
    end
  end

  // word strobe; a position reset wins
  always_ff @(posedge clk) begin
    if (rst) word_valid <= 1'b0;
    else     word_valid <= tick && !pos_rst;
  end

  // per-drive track registers, saturating
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_DRIVES; i++) begin
      if (rst) begin
        trk[i] <= 8'(INIT_TRACK);
      end else if (step_p && motor &&
                   (SW'(i) == drive_sel)) begin
        if (dir) begin
          if (trk[i] < 8'(TRACKS - 1))
            trk[i] <= trk[i] + 8'd1;
        end else begin
          if (trk[i] != 8'd0)
            trk[i] <= trk[i] - 8'd1;
        end
      end
    end
  end

  // status, LBA and fetch handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      motor_q  <= 1'b0;
      sel_q    <= '0;
      evt_q    <= 1'b0;
      ready    <= 1'b0;
      track_no <= '0;
      track0   <= 1'b0;
      lba      <= '0;
      lba_req  <= 1'b0;
    end else begin
      motor_q  <= motor;
      sel_q    <= drive_sel;
      evt_q    <= evt && motor;
      ready    <= motor && (img != 7'd0);
      track_no <= trk_cur;
      track0   <= (trk_cur == 8'd0);
      lba      <= lba_calc(trk_cur, head, sec_no,
                    img, SIDES, SECTORS,
                    SEC_BASE, IMG_SECTORS);
      if (!motor || img == 7'd0)
        lba_req <= 1'b0;
      else if (evt_q)
        lba_req <= 1'b1;
      else if (lba_ack)
        lba_req <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fdd_spin_gen.sv
// Directed bench for fdd_spin_gen with a
// short clock divider.
module tb_fdd_spin_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  drive_sel;
  logic        motor;
  logic        step;
  logic        dir;
  logic        head;
  logic [27:0] disk_img;
  logic [8:0]  word_addr;
  logic        word_valid;
  logic [3:0]  sec_no;
  logic        index;
  logic        track0;
  logic [7:0]  track_no;
  logic        ready;
  logic [31:0] lba;
  logic        lba_req;
  logic        lba_ack;

  int pass_cnt = 0;
  int tot      = 0;

  always #5 clk = ~clk;

  fdd_spin_gen #(.CLK_DIV(4)) dut (
    .pin_25mhz_ck  (clk),
    .ppu_vm_init_i (rst),
    .drive_sel     (drive_sel),
    .motor         (motor),
    .step          (step),
    .dir           (dir),
    .head          (head),
    .disk_img      (disk_img),
    .word_addr     (word_addr),
    .word_valid    (word_valid),
    .sec_no        (sec_no),
    .index         (index),
    .track0        (track0),
    .track_no      (track_no),
    .ready         (ready),
    .lba           (lba),
    .lba_req       (lba_req),
    .lba_ack       (lba_ack)
  );

  typedef struct {
    logic [1:0] sel;
    logic       hd;
    logic       dr;
    int         n;
    int         e_trk;
    logic       e_t0;
    int         e_lba;
    logic       e_rdy;
    logic       e_req;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tot++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_word_addr"}, 32'(word_addr), 0);
    chk({p, "_word_valid"}, 32'(word_valid), 0);
    chk({p, "_sec_no"}, 32'(sec_no), 0);
    chk({p, "_index"}, 32'(index), 0);
    chk({p, "_track0"}, 32'(track0), 0);
    chk({p, "_track_no"}, 32'(track_no), 0);
    chk({p, "_ready"}, 32'(ready), 0);
    chk({p, "_lba"}, lba, 0);
    chk({p, "_lba_req"}, 32'(lba_req), 0);
  endtask

  task automatic step_pulse();
    step = 1'b1;
    repeat (3) @(posedge clk);
    #1 step = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  initial begin
    int c1, c9, c0, wv, ix, fwv, mx0, mx9, n;
    logic idx_end, req3;
    logic [31:0] lba3;

    tbl[0] = '{2'd0, 1'b0, 1'b0, 1, 0, 1'b1,
               4, 1'b1, 1'b1};
    tbl[1] = '{2'd0, 1'b0, 1'b1, 3, 3, 1'b0,
               64, 1'b1, 1'b1};
    tbl[2] = '{2'd1, 1'b1, 1'b1, 5, 5, 1'b0,
               3314, 1'b1, 1'b1};
    tbl[3] = '{2'd0, 1'b1, 1'b0, 1, 2, 1'b0,
               54, 1'b1, 1'b1};
    tbl[4] = '{2'd3, 1'b0, 1'b1, 2, 2, 1'b0,
               1644, 1'b1, 1'b1};
    tbl[5] = '{2'd1, 1'b0, 1'b0, 0, 5, 1'b0,
               3304, 1'b1, 1'b1};
    tbl[6] = '{2'd2, 1'b0, 1'b1, 1, 1, 1'b0,
               0, 1'b0, 1'b0};

    rst = 1'b1; motor = 1'b1; step = 1'b0;
    dir = 1'b0; head = 1'b0; drive_sel = 2'd0;
    lba_ack = 1'b0;
    disk_img = {7'd2, 7'd0, 7'd3, 7'd1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("rst");
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      drive_sel = tbl[i].sel;
      head      = tbl[i].hd;
      dir       = tbl[i].dr;
      repeat (4) @(posedge clk);
      #1;
      repeat (tbl[i].n) step_pulse();
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_track", i),
          32'(track_no), tbl[i].e_trk);
      chk($sformatf("v%0d_track0", i),
          32'(track0), 32'(tbl[i].e_t0));
      chk($sformatf("v%0d_lba", i),
          lba, tbl[i].e_lba);
      chk($sformatf("v%0d_ready", i),
          32'(ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_req", i),
          32'(lba_req), 32'(tbl[i].e_req));
      @(posedge clk);
      #1;
    end

    // one full revolution from motor start
    drive_sel = 2'd0; head = 1'b0;
    motor = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 motor = 1'b1;
    c1 = -1; c9 = -1; c0 = -1; fwv = -1;
    wv = 0; ix = 0; mx0 = 0; mx9 = 0;
    idx_end = 1'b0; req3 = 1'b0; lba3 = '0;
    for (int k = 1; k <= 12500; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (word_valid) begin
        wv++;
        if (fwv < 0) fwv = k;
      end
      if (k < 12500 && index) ix++;
      if (sec_no == 4'd1 && c1 < 0) c1 = k;
      if (sec_no == 4'd9 && c9 < 0) c9 = k;
      if (c9 > 0 && sec_no == 4'd0 && c0 < 0)
        c0 = k;
      if (c1 < 0 && sec_no == 4'd0 &&
          int'(word_addr) > mx0)
        mx0 = int'(word_addr);
      if (sec_no == 4'd9 && int'(word_addr) > mx9)
        mx9 = int'(word_addr);
      if (k == 3) begin
        req3 = lba_req;
        lba3 = lba;
      end
      if (k == 12500) idx_end = index;
    end
    chk("first_word_valid", fwv, 4);
    chk("word_valid_count", wv, 3125);
    chk("sec1_cycle", c1, 1228);
    chk("sec9_cycle", c9, 11052);
    chk("rev_cycle", c0, 12500);
    chk("index_len", ix, 31);
    chk("index_rev", 32'(idx_end), 1);
    chk("sec0_max_word", mx0, 306);
    chk("sec9_max_word", mx9, 361);
    chk("motor_req", 32'(req3), 1);
    chk("motor_lba", lba3, 4);

    // handshake
    repeat (3) @(posedge clk);
    #1 lba_ack = 1'b1;
    @(posedge clk);
    #1 lba_ack = 1'b0;
    @(negedge clk);
    chk("ack_drop", 32'(lba_req), 0);
    lba_ack = 1'b1;
    @(posedge clk);
    #1 lba_ack = 1'b0;
    @(negedge clk);
    chk("ack_idle", 32'(lba_req), 0);
    n = 0;
    while (sec_no != 4'd1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_sec1", 32'(sec_no), 1);
    @(negedge clk);
    chk("sec1_req", 32'(lba_req), 1);
    chk("sec1_lba", lba, 5);
    n = 0;
    while (sec_no != 4'd2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("held_req", 32'(lba_req), 1);
    chk("held_lba", lba, 6);
    lba_ack = 1'b1;
    @(posedge clk);
    #1 lba_ack = 1'b0;
    @(negedge clk);
    chk("held_ack_drop", 32'(lba_req), 0);

    // step edge on the same edge as a word tick
    dir = 1'b1;
    n = 0;
    while (!word_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("tick_seen", 32'(word_valid), 1);
    @(posedge clk);
    #1 step = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("coin_word", 32'(word_addr), 0);
    chk("coin_sec", 32'(sec_no), 0);
    chk("coin_valid", 32'(word_valid), 0);
    @(posedge clk);
    #1 step = 1'b0;
    @(negedge clk);
    chk("coin_req", 32'(lba_req), 1);
    chk("coin_lba", lba, 24);
    chk("coin_track", 32'(track_no), 1);

    // motor drop mid-sector
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("pre_drop_req", 32'(lba_req), 1);
    chk("pre_drop_word", 32'(word_addr != 9'd0), 1);
    motor = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("drop_word", 32'(word_addr), 0);
    chk("drop_sec", 32'(sec_no), 0);
    chk("drop_req", 32'(lba_req), 0);
    chk("drop_ready", 32'(ready), 0);
    chk("drop_index", 32'(index), 0);
    chk("drop_valid", 32'(word_valid), 0);

    // clamp at the last track
    motor = 1'b1;
    @(posedge clk);
    #1;
    repeat (80) step_pulse();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("clamp_track", 32'(track_no), 79);
    chk("clamp_track0", 32'(track0), 0);
    @(posedge clk);
    #1 step_pulse();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("clamp_again", 32'(track_no), 79);

    // reset during an open request
    chk("pre_rst_req", 32'(lba_req), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_rst_track", 32'(track_no), 0);
    chk("post_rst_track0", 32'(track0), 1);

    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end

endmodule
